// File: rtl/mc_control_fsm.sv
// Multicycle RV64 main control FSM with multi-beat D-cache accesses and a stall watchdog.
// Define MC_FSM_TRAP_EN for a recoverable one-cycle trap; otherwise TRAP is terminal.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | request I-cache, latch instruction and PC+4 when not stalled
// DECODE   | classify opcode, precompute PC+imm
// MEMADDR  | compute rs1+imm, clear beat counter
// MEMREAD  | D-cache read beats
// MEMWB    | write loaded data to rd
// MEMWRITE | D-cache write beats
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to rd
// JAL      | redirect PC to jump target
// BRANCH   | compare and conditionally redirect PC
// LOADI    | write upper immediate to rd
// TRAP     | system / illegal instruction
module mc_control_fsm #(
    parameter int MEM_BEATS     = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic [6:0] i_op,
    input  logic [2:0] i_func_3,
    input  logic       i_func_7_5,
    input  logic       i_stall_instr,
    input  logic       i_stall_data,
    input  logic       i_access_split,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_1,
    output logic [1:0] o_alu_src_2,
    output logic       o_reg_write_en,
    output logic       o_pc_update,
    output logic       o_mem_write_en,
    output logic       o_instr_write_en,
    output logic       o_addr_write_en,
    output logic       o_start_i_cache,
    output logic       o_start_d_cache,
    output logic       o_branch,
    output logic       o_mem_reg_we,
    output logic [((MEM_BEATS > 1) ? $clog2(MEM_BEATS) : 1)-1:0] o_beat_idx,
    output logic       o_timeout,
    output logic       o_trap,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    localparam int BW = (MEM_BEATS > 1) ? $clog2(MEM_BEATS) : 1;
    localparam int WW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MEM_BEATS - 1);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(STALL_TIMEOUT);
    localparam logic [WW-1:0] WD_PRE    = WW'(STALL_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_IMM       = 7'b0010011;
    localparam logic [6:0] OP_IMM_32    = 7'b0011011;
    localparam logic [6:0] OP_REG       = 7'b0110011;
    localparam logic [6:0] OP_REG_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_FENCE     = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LOADI    = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        K_LOAD  = 2'd0,
        K_STORE = 2'd1,
        K_JALR  = 2'd2
    } mem_kind_t;

    state_t          state_q, state_d;
    mem_kind_t       kind_q, kind_d;
    logic            is_w_q, is_w_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            illegal_q, illegal_d;
    logic            stalled;

    // funct fields are consumed by the ALU decoder in the datapath, not here
    logic unused_funct;
    assign unused_funct = ^{i_func_3, i_func_7_5};

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        is_w_d    = is_w_q;
        beat_d    = beat_q;
        timeout_d = timeout_q;
        illegal_d = illegal_q;

        stalled = ((state_q == S_FETCH) && i_stall_instr) ||
                  (((state_q == S_MEMREAD) || (state_q == S_MEMWRITE)) && i_stall_data);

        case (state_q)
            S_FETCH: if (!i_stall_instr) state_d = S_DECODE;
            S_DECODE: begin
                is_w_d = (i_op == OP_REG_32) || (i_op == OP_IMM_32);
                case (i_op)
                    OP_LOAD:   begin state_d = S_MEMADDR; kind_d = K_LOAD;  end
                    OP_STORE:  begin state_d = S_MEMADDR; kind_d = K_STORE; end
                    OP_JALR:   begin state_d = S_MEMADDR; kind_d = K_JALR;  end
                    OP_IMM, OP_IMM_32: state_d = S_EXECI;
                    OP_REG, OP_REG_32: state_d = S_EXECR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_AUIPC:  state_d = S_ALUWB;
                    OP_LUI:    state_d = S_LOADI;
                    OP_FENCE:  state_d = S_FETCH;
                    OP_SYSTEM: state_d = S_TRAP;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                beat_d = '0;
                case (kind_q)
                    K_LOAD:  state_d = S_MEMREAD;
                    K_STORE: state_d = S_MEMWRITE;
                    default: state_d = S_JAL;
                endcase
            end
            S_MEMREAD, S_MEMWRITE: begin
                if (!i_stall_data) begin
                    // a split request on the last legal beat saturates instead of wrapping
                    if (i_access_split && (beat_q < LAST_BEAT)) begin
                        beat_d = beat_q + BW'(1);
                    end else begin
                        beat_d  = '0;
                        state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                    end
                end
            end
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_LOADI, S_BRANCH: state_d = S_FETCH;
`ifdef MC_FSM_TRAP_EN
            S_TRAP: state_d = S_FETCH;
`else
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

        if (!stalled) begin
            wd_d = '0;
        end else if (wd_q == WD_LIMIT) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WW'(1);
        end
        if (stalled && (wd_q == WD_PRE)) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= S_FETCH;
            kind_q    <= K_LOAD;
            is_w_q    <= 1'b0;
            beat_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            is_w_q    <= is_w_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        o_alu_op         = 2'b00;
        o_result_src     = 2'b00;
        o_alu_src_1      = 2'b00;
        o_alu_src_2      = 2'b00;
        o_reg_write_en   = 1'b0;
        o_pc_update      = 1'b0;
        o_mem_write_en   = 1'b0;
        o_instr_write_en = 1'b0;
        o_addr_write_en  = 1'b0;
        o_start_i_cache  = 1'b0;
        o_start_d_cache  = 1'b0;
        o_branch         = 1'b0;
        o_mem_reg_we     = 1'b0;
        o_trap           = 1'b0;

        case (state_q)
            S_FETCH: begin
                o_start_i_cache = 1'b1;
                o_alu_src_2     = 2'b10;
                o_result_src    = 2'b10;
                if (!i_stall_instr) begin
                    o_instr_write_en = 1'b1;
                    o_addr_write_en  = 1'b1;
                    o_pc_update      = 1'b1;
                end
            end
            S_DECODE: begin
                o_alu_src_1 = 2'b01;
                o_alu_src_2 = 2'b01;
            end
            S_MEMADDR: begin
                o_alu_src_1 = 2'b10;
                o_alu_src_2 = 2'b01;
            end
            S_MEMREAD, S_MEMWRITE: begin
                o_start_d_cache = 1'b1;
                if (beat_q == '0) begin
                    o_alu_src_1 = 2'b10;
                    o_alu_src_2 = 2'b01;
                end else begin
                    o_alu_src_1 = 2'b11;
                    o_alu_src_2 = 2'b10;
                end
                if (i_stall_data) begin
                    o_addr_write_en = 1'b1;
                end else begin
                    o_mem_reg_we   = 1'b1;
                    o_mem_write_en = (state_q == S_MEMWRITE);
                end
            end
            S_MEMWB: begin
                o_reg_write_en = 1'b1;
                o_result_src   = 2'b01;
            end
            S_EXECR: begin
                o_alu_src_1 = 2'b10;
                o_alu_op    = is_w_q ? 2'b11 : 2'b10;
            end
            S_EXECI: begin
                o_alu_src_1 = 2'b10;
                o_alu_src_2 = 2'b01;
                o_alu_op    = is_w_q ? 2'b11 : 2'b10;
            end
            S_ALUWB: o_reg_write_en = 1'b1;
            S_JAL: begin
                o_alu_src_1 = 2'b01;
                o_alu_src_2 = 2'b10;
                o_pc_update = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_1 = 2'b10;
                o_alu_op    = 2'b01;
                o_branch    = 1'b1;
            end
            S_LOADI: begin
                o_alu_src_1    = 2'b11;
                o_alu_src_2    = 2'b01;
                o_result_src   = 2'b10;
                o_reg_write_en = 1'b1;
            end
            S_TRAP: begin
                o_trap = 1'b1;
`ifdef MC_FSM_TRAP_EN
                o_pc_update  = 1'b1;
                o_result_src = 2'b11;
`endif
            end
            default: ;
        endcase
    end

    assign o_beat_idx = beat_q;
    assign o_timeout  = timeout_q;
    assign o_illegal  = illegal_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (default parameters); trap checks follow MC_FSM_TRAP_EN.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       arstn;
    logic [6:0] i_op;
    logic [2:0] i_func_3;
    logic       i_func_7_5;
    logic       i_stall_instr;
    logic       i_stall_data;
    logic       i_access_split;
    logic [1:0] o_alu_op, o_result_src, o_alu_src_1, o_alu_src_2;
    logic       o_reg_write_en, o_pc_update, o_mem_write_en, o_instr_write_en;
    logic       o_addr_write_en, o_start_i_cache, o_start_d_cache, o_branch, o_mem_reg_we;
    logic [0:0] o_beat_idx;
    logic       o_timeout, o_trap, o_illegal;
    logic [3:0] o_state;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_JAL = 4'd9, S_BRANCH = 4'd10, S_LOADI = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd12;

    mc_control_fsm dut (
        .clk(clk), .arstn(arstn), .i_op(i_op), .i_func_3(i_func_3), .i_func_7_5(i_func_7_5),
        .i_stall_instr(i_stall_instr), .i_stall_data(i_stall_data), .i_access_split(i_access_split),
        .o_alu_op(o_alu_op), .o_result_src(o_result_src), .o_alu_src_1(o_alu_src_1),
        .o_alu_src_2(o_alu_src_2), .o_reg_write_en(o_reg_write_en), .o_pc_update(o_pc_update),
        .o_mem_write_en(o_mem_write_en), .o_instr_write_en(o_instr_write_en),
        .o_addr_write_en(o_addr_write_en), .o_start_i_cache(o_start_i_cache),
        .o_start_d_cache(o_start_d_cache), .o_branch(o_branch), .o_mem_reg_we(o_mem_reg_we),
        .o_beat_idx(o_beat_idx), .o_timeout(o_timeout), .o_trap(o_trap), .o_illegal(o_illegal),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        #2;
        arstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        i_op = 7'h00; i_func_3 = 3'b000; i_func_7_5 = 1'b0;
        i_stall_instr = 1'b0; i_stall_data = 1'b0; i_access_split = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (o_state !== S_FETCH) $display("FAIL reset_state: got %0d want %0d", o_state, S_FETCH);
        else n_pass++;
        n_total++;
        if ({o_beat_idx, o_timeout, o_illegal, o_trap} !== 4'b0000)
            $display("FAIL reset_flags: got beat/to/ill/trap %b want 0000", {o_beat_idx, o_timeout, o_illegal, o_trap});
        else n_pass++;
        n_total++;
        if (o_mem_write_en !== 1'b0) $display("FAIL reset_memwe: got %b want 0", o_mem_write_en);
        else n_pass++;
        arstn = 1'b1;
    endtask

    task automatic test_alu();
        logic [6:0]  ops [4] = '{7'h33, 7'h3B, 7'h13, 7'h1B};
        logic [3:0]  exs [4] = '{S_EXECR, S_EXECR, S_EXECI, S_EXECI};
        logic [1:0]  aop [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
        logic [4:0]  we_seq;
        logic [19:0] st_seq, st_exp;
        logic [1:0]  got_aop;
        for (int i = 0; i < 4; i++) begin
            i_op = ops[i];
            i_stall_instr = 1'b0;
            i_stall_data = 1'b0;
            do_reset();
            got_aop = 2'b00;
            for (int c = 0; c < 5; c++) begin
                we_seq[c] = o_reg_write_en;
                st_seq[c*4 +: 4] = o_state;
                if (c == 2) got_aop = o_alu_op;
                tick();
            end
            st_exp = {S_FETCH, S_ALUWB, exs[i], S_DECODE, S_FETCH};
            n_total++;
            if (st_seq !== st_exp) $display("FAIL alu_states op=%h: got %h want %h", ops[i], st_seq, st_exp);
            else n_pass++;
            n_total++;
            if (got_aop !== aop[i]) $display("FAIL alu_op op=%h: got %b want %b", ops[i], got_aop, aop[i]);
            else n_pass++;
            n_total++;
            if (we_seq !== 5'b01000) $display("FAIL alu_regwe op=%h: got %b want 01000", ops[i], we_seq);
            else n_pass++;
        end
    endtask

    task automatic test_dispatch();
        logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h67, 7'h13, 7'h1B, 7'h33,
                                 7'h3B, 7'h63, 7'h6F, 7'h17, 7'h37, 7'h0F};
        logic [3:0] s1  [12] = '{S_MEMADDR, S_MEMADDR, S_MEMADDR, S_EXECI, S_EXECI, S_EXECR,
                                 S_EXECR, S_BRANCH, S_JAL, S_ALUWB, S_LOADI, S_FETCH};
        logic [3:0] s2  [12] = '{S_MEMREAD, S_MEMWRITE, S_JAL, S_ALUWB, S_ALUWB, S_ALUWB,
                                 S_ALUWB, S_FETCH, S_ALUWB, S_FETCH, S_FETCH, S_DECODE};
        for (int i = 0; i < 12; i++) begin
            i_op = ops[i];
            i_stall_instr = 1'b0;
            i_stall_data = 1'b0;
            i_access_split = 1'b0;
            do_reset();
            tick();
            tick();
            n_total++;
            if (o_state !== s1[i]) $display("FAIL dispatch op=%h: got %0d want %0d", ops[i], o_state, s1[i]);
            else n_pass++;
            tick();
            n_total++;
            if (o_state !== s2[i]) $display("FAIL follow op=%h: got %0d want %0d", ops[i], o_state, s2[i]);
            else n_pass++;
        end
    endtask

    task automatic test_load_split();
        logic [7:0] stall_pat = 8'b01110111;
        logic [7:0] beat_seq, we_seq, awe_seq, src0_seq, src1_seq;
        logic       st_ok;
        i_op = 7'h03;
        i_stall_instr = 1'b0;
        i_stall_data = 1'b0;
        i_access_split = 1'b1;
        do_reset();
        tick(); tick(); tick();
        st_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_stall_data = stall_pat[c];
            #1;
            beat_seq[c] = o_beat_idx[0];
            we_seq[c]   = o_mem_reg_we;
            awe_seq[c]  = o_addr_write_en;
            src0_seq[c] = (o_alu_src_1 == 2'b10) && (o_alu_src_2 == 2'b01);
            src1_seq[c] = (o_alu_src_1 == 2'b11) && (o_alu_src_2 == 2'b10);
            if (o_state !== S_MEMREAD || o_mem_write_en !== 1'b0) st_ok = 1'b0;
            tick();
        end
        n_total++;
        if (!st_ok) $display("FAIL load_hold: state left MEMREAD or write enable seen, got 0 want 1");
        else n_pass++;
        n_total++;
        if (beat_seq !== 8'b11110000) $display("FAIL load_beat: got %b want 11110000", beat_seq);
        else n_pass++;
        n_total++;
        if (we_seq !== 8'b10001000) $display("FAIL load_memregwe: got %b want 10001000", we_seq);
        else n_pass++;
        n_total++;
        if (awe_seq !== stall_pat) $display("FAIL load_addrwe: got %b want %b", awe_seq, stall_pat);
        else n_pass++;
        n_total++;
        if ({src1_seq, src0_seq} !== 16'hF00F) $display("FAIL load_src: got %h want f00f", {src1_seq, src0_seq});
        else n_pass++;
        i_stall_data = 1'b0;
        n_total++;
        if ({o_state, o_reg_write_en, o_result_src} !== {S_MEMWB, 1'b1, 2'b01})
            $display("FAIL load_memwb: got st=%0d we=%b rs=%b want st=4 we=1 rs=01", o_state, o_reg_write_en, o_result_src);
        else n_pass++;
        tick();
        n_total++;
        if (o_state !== S_FETCH) $display("FAIL load_return: got %0d want %0d", o_state, S_FETCH);
        else n_pass++;
    endtask

    task automatic test_store_split();
        logic [2:0] stall_pat = 3'b001;
        logic [2:0] mwe_seq, beat_seq;
        i_op = 7'h23;
        i_stall_instr = 1'b0;
        i_stall_data = 1'b0;
        i_access_split = 1'b1;
        do_reset();
        tick(); tick(); tick();
        for (int c = 0; c < 3; c++) begin
            i_stall_data = stall_pat[c];
            #1;
            mwe_seq[c]  = o_mem_write_en;
            beat_seq[c] = o_beat_idx[0];
            tick();
        end
        n_total++;
        if (mwe_seq !== 3'b110) $display("FAIL store_memwe: got %b want 110", mwe_seq);
        else n_pass++;
        n_total++;
        if (beat_seq !== 3'b100) $display("FAIL store_beat: got %b want 100", beat_seq);
        else n_pass++;
        n_total++;
        if (o_state !== S_FETCH) $display("FAIL store_return: got %0d want %0d", o_state, S_FETCH);
        else n_pass++;
    endtask

    task automatic test_timeout();
        i_op = 7'h0F;
        i_stall_data = 1'b0;
        i_stall_instr = 1'b1;
        do_reset();
        repeat (1000) tick();
        i_stall_instr = 1'b0;
        tick();
        n_total++;
        if (o_state !== S_DECODE) $display("FAIL wd_release: got %0d want %0d", o_state, S_DECODE);
        else n_pass++;
        i_stall_instr = 1'b1;
        tick();
        repeat (1023) tick();
        n_total++;
        if ({o_state, o_timeout} !== {S_FETCH, 1'b0})
            $display("FAIL wd_1023: got st=%0d to=%b want st=0 to=0", o_state, o_timeout);
        else n_pass++;
        tick();
        n_total++;
        if (o_timeout !== 1'b1) $display("FAIL wd_1024: got %b want 1", o_timeout);
        else n_pass++;
        repeat (5) tick();
        n_total++;
        if ({o_state, o_timeout} !== {S_FETCH, 1'b1})
            $display("FAIL wd_saturate: got st=%0d to=%b want st=0 to=1", o_state, o_timeout);
        else n_pass++;
        i_stall_instr = 1'b0;
        tick();
        n_total++;
        if ({o_state, o_timeout} !== {S_DECODE, 1'b1})
            $display("FAIL wd_sticky: got st=%0d to=%b want st=1 to=1", o_state, o_timeout);
        else n_pass++;
        do_reset();
        n_total++;
        if (o_timeout !== 1'b0) $display("FAIL wd_reset: got %b want 0", o_timeout);
        else n_pass++;
    endtask

    task automatic test_illegal();
        i_stall_instr = 1'b0;
        i_stall_data = 1'b0;
        i_op = 7'h7F;
        do_reset();
        tick();
        n_total++;
        if (o_illegal !== 1'b0) $display("FAIL ill_early: got %b want 0", o_illegal);
        else n_pass++;
        tick();
        n_total++;
        if ({o_state, o_illegal, o_trap} !== {S_TRAP, 1'b1, 1'b1})
            $display("FAIL ill_trap: got st=%0d ill=%b trap=%b want st=12 ill=1 trap=1", o_state, o_illegal, o_trap);
        else n_pass++;
`ifdef MC_FSM_TRAP_EN
        n_total++;
        if ({o_pc_update, o_result_src} !== 3'b111)
            $display("FAIL trap_vector: got pc=%b rs=%b want pc=1 rs=11", o_pc_update, o_result_src);
        else n_pass++;
        tick();
        n_total++;
        if ({o_state, o_trap, o_illegal} !== {S_FETCH, 1'b0, 1'b1})
            $display("FAIL trap_return: got st=%0d trap=%b ill=%b want st=0 trap=0 ill=1", o_state, o_trap, o_illegal);
        else n_pass++;
`else
        repeat (3) tick();
        n_total++;
        if ({o_state, o_trap} !== {S_TRAP, 1'b1})
            $display("FAIL trap_stuck: got st=%0d trap=%b want st=12 trap=1", o_state, o_trap);
        else n_pass++;
        n_total++;
        if ({o_pc_update, o_reg_write_en, o_mem_write_en, o_instr_write_en, o_addr_write_en} !== 5'b00000)
            $display("FAIL trap_enables: got %b want 00000",
                     {o_pc_update, o_reg_write_en, o_mem_write_en, o_instr_write_en, o_addr_write_en});
        else n_pass++;
`endif
        do_reset();
        n_total++;
        if ({o_illegal, o_trap} !== 2'b00) $display("FAIL ill_reset: got %b want 00", {o_illegal, o_trap});
        else n_pass++;
        i_op = 7'h73;
        tick();
        tick();
        n_total++;
        if ({o_state, o_illegal} !== {S_TRAP, 1'b0})
            $display("FAIL system_trap: got st=%0d ill=%b want st=12 ill=0", o_state, o_illegal);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        i_op = 7'h23;
        i_stall_instr = 1'b0;
        i_stall_data = 1'b0;
        i_access_split = 1'b1;
        do_reset();
        tick(); tick(); tick();
        tick();
        i_stall_data = 1'b1;
        #1;
        n_total++;
        if ({o_state, o_beat_idx, o_mem_write_en, o_addr_write_en} !== {S_MEMWRITE, 1'b1, 1'b0, 1'b1})
            $display("FAIL mw_stall: got st=%0d beat=%b we=%b awe=%b want st=5 beat=1 we=0 awe=1",
                     o_state, o_beat_idx, o_mem_write_en, o_addr_write_en);
        else n_pass++;
        tick();
        tick();
        arstn = 1'b0;
        #1;
        n_total++;
        if ({o_state, o_beat_idx, o_mem_write_en, o_mem_reg_we} !== {S_FETCH, 1'b0, 1'b0, 1'b0})
            $display("FAIL mw_reset: got st=%0d beat=%b we=%b mrwe=%b want st=0 beat=0 we=0 mrwe=0",
                     o_state, o_beat_idx, o_mem_write_en, o_mem_reg_we);
        else n_pass++;
        tick();
        arstn = 1'b1;
        #1;
        n_total++;
        if ({o_state, o_beat_idx, o_mem_write_en, o_timeout} !== {S_FETCH, 1'b0, 1'b0, 1'b0})
            $display("FAIL mw_release: got st=%0d beat=%b we=%b to=%b want st=0 beat=0 we=0 to=0",
                     o_state, o_beat_idx, o_mem_write_en, o_timeout);
        else n_pass++;
        tick();
        n_total++;
        if (o_state !== S_DECODE) $display("FAIL mw_resume: got %0d want %0d", o_state, S_DECODE);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_dispatch();
        test_load_split();
        test_store_split();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish before 500000");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MEM_BEATS, default 2, meaning the maximum number of data-cache beats per load/store (legal range 1..4).
REQ-002 SHALL have parameter STALL_TIMEOUT, default 1024, meaning consecutive stall cycles before the watchdog flags (legal range ≥2).
REQ-003 SHALL have the following ports (name, direction, width, meaning); clk and arstn are the single clock and the asynchronous active-low reset:
- clk in 1: clock.
- arstn in 1: asynchronous reset, active-low.
- i_op in 7: opcode.
- i_func_3 in 3: funct3.
- i_func_7_5 in 1: funct7 bit 5.
- i_stall_instr in 1: I-cache busy.
- i_stall_data in 1: D-cache busy.
- i_access_split in 1: current access needs a further beat.
- o_alu_op, o_result_src, o_alu_src_1, o_alu_src_2 out 2: datapath selects, encodings unchanged from the current main FSM.
- o_reg_write_en, o_pc_update, o_mem_write_en, o_instr_write_en, o_addr_write_en, o_start_i_cache, o_start_d_cache, o_branch, o_mem_reg_we out 1 each: datapath enables.
- o_beat_idx out $clog2(MEM_BEATS) (minimum 1): current beat.
- o_timeout out 1: sticky watchdog flag.
- o_trap out 1: trap pulse.
- o_illegal out 1: undecodable opcode seen.
- o_state out 4: present state encoding.

Function
REQ-004 SHALL implement states FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, LOADI and TRAP; all outputs SHALL be decoded from the registered state plus the current stall inputs only.
REQ-005 FETCH SHALL hold while i_stall_instr=1; otherwise it SHALL assert o_instr_write_en, o_addr_write_en and o_pc_update for one cycle and go to DECODE; o_start_i_cache=1 throughout FETCH.
REQ-006 DECODE SHALL go to the following next states:
- load, store, JALR → MEMADDR;
- OP-IMM, OP-IMM-32 → EXECI;
- OP, OP-32 → EXECR;
- BRANCH → BRANCH;
- JAL → JAL;
- AUIPC → ALUWB;
- LUI → LOADI;
- FENCE → FETCH;
- SYSTEM or unknown opcode → TRAP.
REQ-007 EXECR/EXECI SHALL drive o_alu_op=10 for 64-bit forms and 11 for -W forms, then go to ALUWB; ALUWB, LOADI and BRANCH SHALL last one cycle and return to FETCH.
REQ-008 MEMADDR SHALL go to MEMREAD (load), MEMWRITE (store) or JAL (JALR) and clear the beat counter.
REQ-009 In MEMREAD/MEMWRITE, o_start_d_cache=1; while i_stall_data=1 the state and beat counter SHALL hold, o_addr_write_en=1 and o_mem_write_en=0.
REQ-010 A non-stalled cycle in MEMREAD/MEMWRITE SHALL assert o_mem_reg_we (and o_mem_write_en in MEMWRITE).
- If i_access_split=1 and beat < MEM_BEATS-1: beat SHALL increment and the state SHALL hold.
- Otherwise: MEMREAD → MEMWB and MEMWRITE → FETCH.
REQ-011 o_beat_idx SHALL equal the beat counter.
- Beat 0 SHALL select alu_src 10/01; beats ≥1 SHALL select 11/10.
- i_access_split on the last legal beat SHALL be ignored (saturation, no wrap).
REQ-012 MEMWB SHALL assert o_reg_write_en with o_result_src=01 for one cycle.
REQ-013 The watchdog counter SHALL count consecutive cycles with a stall asserted in FETCH/MEMREAD/MEMWRITE and clear on any non-stalled cycle.
- On reaching STALL_TIMEOUT it SHALL set o_timeout (sticky until reset) and saturate.
- The FSM SHALL keep waiting.
REQ-014 o_illegal SHALL be set sticky in DECODE for an unknown opcode.

Reset
REQ-015 While arstn=0, state SHALL be FETCH, beat and watchdog counters 0, and o_timeout=o_illegal=o_trap=0; reset mid-access SHALL abandon the access with no write enable asserted.

Configuration
REQ-016 Macro MC_FSM_TRAP_EN SHALL select TRAP-state behaviour.
- Defined: TRAP SHALL pulse o_trap for one cycle with o_pc_update=1 and o_result_src=11 (trap vector), then go to FETCH.
- Undefined: TRAP SHALL be terminal; o_trap SHALL be held 1 until reset with all enables 0.

Verification
REQ-017 ADD, no stalls → FETCH,DECODE,EXECR,ALUWB; one o_reg_write_en pulse in cycle 4.
REQ-018 Load with MEM_BEATS=2, i_access_split=1 on beat 0, 3 stall cycles per beat → o_mem_reg_we exactly twice, o_beat_idx 0 then 1, MEMWB reached.
REQ-019 Store with MEM_BEATS=2 and i_access_split held 1 → exactly 2 o_mem_write_en pulses, then FETCH.
REQ-020 i_stall_instr held for 1024 cycles → o_timeout rises on cycle 1024 and stays 1 after the stall clears.
REQ-021 Opcode 7'h7F, macro defined → o_illegal=1, one o_trap pulse, then FETCH; macro undefined → o_trap stuck at 1.
REQ-022 arstn deasserted-then-asserted mid-MEMWRITE stall → FETCH state, counters 0, no o_mem_write_en.
